// File: rtl/bit_rotator_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bit_rotator_feed_ctrl
// Brief    : Streams a frame column-major (16-pixel words, col descending per
//            strip) from frame memory through a 2-entry skid FIFO to a rotator.
// Revision : 1.0 - initial release
// ============================================================================
module bit_rotator_feed_ctrl #(
    parameter int frame_width  = 128,
    parameter int frame_height = 128,
    parameter int addr_width   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [addr_width-1:0] rd_addr,
    input  logic [15:0]           rd_data,
    output logic [15:0]           bit_pix,
    output logic                  bit_pix_valid,
    input  logic                  ds_ready
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic [addr_width-1:0] c_col_last   = addr_width'(frame_width - 1);
    localparam logic [addr_width-1:0] c_strip_last = addr_width'(frame_height / 16 - 1);
    localparam logic [addr_width-1:0] c_width      = addr_width'(frame_width);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [addr_width-1:0] r_col;
    logic [addr_width-1:0] r_strip;
    logic [15:0]           r_mem [0:1];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_inflight;

    logic                  w_last_addr;
    logic                  w_start_ok;
    logic [1:0]            w_level;
    logic                  w_mem_push;
    logic                  w_mem_pop;

    assign w_last_addr = (r_strip == c_strip_last) && (r_col == '0);
    assign w_start_ok  = (r_state == c_idle) && start && !abort;
    assign w_level     = r_count + {1'b0, r_inflight};
    assign rd_addr     = r_strip * c_width + r_col;

    // Empty FIFO falls through: the word arriving from memory is presented
    // directly, which gives the 2-cycle start latency at full throughput.
    assign bit_pix_valid = ((r_count != 2'd0) || r_inflight) && ds_ready;
    assign bit_pix       = (r_count != 2'd0) ? r_mem[r_rd_ptr] :
                           (r_inflight ? rd_data : 16'h0000);
    assign w_mem_pop     = bit_pix_valid && (r_count != 2'd0);
    assign w_mem_push    = r_inflight && !((r_count == 2'd0) && bit_pix_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_start_ok) w_next_state = c_run;
            c_run: begin
                if (abort)                    w_next_state = c_idle;
                else if (rd_en && w_last_addr) w_next_state = c_drain;
            end
            c_drain: begin
                if (abort)                                      w_next_state = c_idle;
                else if ((r_count == 2'd0) && !r_inflight)      w_next_state = c_done;
            end
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        rd_en = 1'b0;
        case (r_state)
            c_run: begin
                busy  = 1'b1;
                rd_en = (w_level < 2'd2);
            end
            c_drain: busy = 1'b1;
            c_done: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col      <= '0;
            r_strip    <= '0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else if (abort) begin
            // Drop everything, including the word still coming back from memory
            r_col      <= '0;
            r_strip    <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= rd_en;
            if (w_start_ok) begin
                r_col   <= c_col_last;
                r_strip <= '0;
            end else if (rd_en) begin
                if (w_last_addr) begin
                    r_col   <= '0;
                    r_strip <= '0;
                end else if (r_col == '0) begin
                    r_col   <= c_col_last;
                    r_strip <= r_strip + 1'b1;
                end else begin
                    r_col   <= r_col - 1'b1;
                end
            end
            if (w_mem_push) begin
                r_mem[r_wr_ptr] <= rd_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_mem_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_mem_push} - {1'b0, w_mem_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_rotator_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_rotator_feed_ctrl
// Brief    : Directed self-checking bench for bit_rotator_feed_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_rotator_feed_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [15:0] rd_data = 16'h0000;
    logic [15:0] bit_pix;
    logic        bit_pix_valid;
    logic        ds_ready = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    bit_rotator_feed_ctrl #(
        .frame_width  (128),
        .frame_height (128),
        .addr_width   (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .bit_pix       (bit_pix),
        .bit_pix_valid (bit_pix_valid),
        .ds_ready      (ds_ready)
    );

    always #5 clk = ~clk;

    // Frame memory: each word holds its own address, one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= {6'b0, rd_addr};
    end

    function automatic logic [15:0] exp_word(input int k);
        int s;
        int c;
        s = k / 128;
        c = 127 - (k % 128);
        return 16'(s * 128 + c);
    endfunction

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, rd_en, bit_pix_valid, rd_addr, bit_pix} !== 30'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd_en=%b valid=%b addr=%0d pix=%0d, want all 0",
                     busy, done, rd_en, bit_pix_valid, rd_addr, bit_pix);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_hold: got busy=%b rd_en=%b, want 0 0", busy, rd_en);
        end
    endtask

    task automatic test_full_frame(input bit random_ready);
        int  k = 0;
        int  cyc;
        int  outstanding = 0;
        int  first_cyc = -1;
        int  done_cyc = -1;
        bit  pulsed = 1'b0;
        @(negedge clk);
        ds_ready = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (done_cyc < 0 && cyc < 6000) begin
            if (random_ready) ds_ready = 1'($urandom_range(0, 1));
            start = (k == 600) && !pulsed;
            if (start) pulsed = 1'b1;
            #1;
            if (cyc == 1) begin
                n_vec++;
                if (rd_en !== 1'b1 || rd_addr !== 10'd127) begin
                    n_err++;
                    $display("FAIL first_read: got rd_en=%b addr=%0d, want 1 127", rd_en, rd_addr);
                end
            end
            if (random_ready) begin
                n_vec++;
                if (outstanding > 2 || (outstanding == 2 && rd_en === 1'b1)) begin
                    n_err++;
                    $display("FAIL fifo_bound: got outstanding=%0d rd_en=%b, want <2 when reading", outstanding, rd_en);
                end
            end
            if (bit_pix_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                n_vec++;
                if (bit_pix !== exp_word(k)) begin
                    n_err++;
                    $display("FAIL word_%0d: got %0d, want %0d", k, bit_pix, exp_word(k));
                end
                k++;
            end
            if (done === 1'b1) done_cyc = cyc;
            outstanding = outstanding + int'(rd_en) - int'(bit_pix_valid);
            if (done_cyc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        n_vec++;
        if (k != 1024 || done_cyc < 0) begin
            n_err++;
            $display("FAIL frame_count: got %0d words done_cycle=%0d, want 1024 words and a done", k, done_cyc);
        end
        if (!random_ready) begin
            n_vec++;
            if (first_cyc != 2 || done_cyc != 1027) begin
                n_err++;
                $display("FAIL frame_timing: got first_valid=%0d done=%0d, want 2 1027", first_cyc, done_cyc);
            end
        end
        @(negedge clk);
        ds_ready = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL post_done_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_stall();
        int k = 0;
        int cyc = 1;
        int stall_i = -1;
        bit seen_done = 1'b0;
        @(negedge clk);
        ds_ready = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!seen_done && cyc < 3000) begin
            if (k == 100 && stall_i < 0) stall_i = 0;
            ds_ready = !(stall_i >= 0 && stall_i < 20);
            #1;
            if (stall_i >= 0 && stall_i < 20) begin
                n_vec++;
                if (bit_pix_valid !== 1'b0 || bit_pix !== exp_word(100) ||
                    (stall_i >= 2 && rd_en !== 1'b0)) begin
                    n_err++;
                    $display("FAIL stall_%0d: got valid=%b pix=%0d rd_en=%b, want 0 %0d rd_en 0",
                             stall_i, bit_pix_valid, bit_pix, rd_en, exp_word(100));
                end
                stall_i++;
            end else if (bit_pix_valid === 1'b1) begin
                n_vec++;
                if (bit_pix !== exp_word(k)) begin
                    n_err++;
                    $display("FAIL stall_word_%0d: got %0d, want %0d", k, bit_pix, exp_word(k));
                end
                k++;
            end
            if (done === 1'b1) seen_done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        ds_ready = 1'b1;
        n_vec++;
        if (k != 1024 || !seen_done) begin
            n_err++;
            $display("FAIL stall_frame: got %0d words done=%b, want 1024 1", k, seen_done);
        end
    endtask

    task automatic test_abort();
        int k = 0;
        int cyc = 1;
        int stray = 0;
        @(negedge clk);
        ds_ready = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (k < 300 && cyc < 1000) begin
            #1;
            if (bit_pix_valid === 1'b1) k++;
            if (k < 300) begin
                @(negedge clk);
                cyc++;
            end
        end
        n_vec++;
        if (k != 300 || bit_pix !== exp_word(299)) begin
            n_err++;
            $display("FAIL abort_reach: got %0d words pix=%0d, want 300 %0d", k, bit_pix, exp_word(299));
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || bit_pix_valid !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_next: got busy=%b valid=%b rd_en=%b done=%b, want 0 0 0 0",
                     busy, bit_pix_valid, rd_en, done);
        end
        repeat (10) begin
            @(negedge clk);
            #1;
            if (bit_pix_valid === 1'b1 || done === 1'b1) stray++;
        end
        n_vec++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d stray valid/done cycles, want 0", stray);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_vec++;
        if (rd_en !== 1'b1 || rd_addr !== 10'd127) begin
            n_err++;
            $display("FAIL abort_restart_addr: got rd_en=%b addr=%0d, want 1 127", rd_en, rd_addr);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (bit_pix_valid !== 1'b1 || bit_pix !== 16'd127) begin
            n_err++;
            $display("FAIL abort_restart_word: got valid=%b pix=%0d, want 1 127", bit_pix_valid, bit_pix);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int k = 0;
        int cyc = 1;
        @(negedge clk);
        ds_ready = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (k < 500 && cyc < 1000) begin
            #1;
            if (bit_pix_valid === 1'b1) k++;
            if (k < 500) begin
                @(negedge clk);
                cyc++;
            end
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (k != 500 || {busy, done, rd_en, bit_pix_valid, rd_addr, bit_pix} !== 30'd0) begin
            n_err++;
            $display("FAIL reset_mid: got words=%0d busy=%b done=%b rd_en=%b valid=%b addr=%0d pix=%0d, want 500 and all 0",
                     k, busy, done, rd_en, bit_pix_valid, rd_addr, bit_pix);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_idle: got busy=%b, want 0", busy);
        end
        test_full_frame(1'b0);
    endtask

    task automatic test_start_abort_same_cycle();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort_collision: got busy=%b rd_en=%b, want 0 0", busy, rd_en);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || bit_pix_valid !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort_idle: got busy=%b valid=%b, want 0 0", busy, bit_pix_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame(1'b0);
        test_full_frame(1'b1);
        test_stall();
        test_abort();
        test_reset_mid_frame();
        test_start_abort_same_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
